epl_accumulator: RTL and testbench
==================================

# epl_accumulator

Tracking-channel correlator stage directly downstream of the C/A code generator. Each input sample's carrier-wiped I and Q values are multiplied by the early, prompt and late code chips, and six integrate-and-dump accumulators sum the products. The sums are latched on the code generator's `dump_enable`. The block exposes the latched sums with a new-data flag and an overrun flag for the channel's CPU read path.

## Interface
Parameters:
- `IN_W`, 3: width of the signed two's-complement baseband I/Q samples.
- `ACC_W`, 16: width of each signed accumulator and latched output. Must satisfy `ACC_W > IN_W + 1`.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `chan_clear` in 1: synchronous pulse that clears all state (issued with the PRN key load).
- `sample_enable` in 1: one-cycle pulse marking a valid `i_bb`/`q_bb`.
- `i_bb`, `q_bb` in IN_W: signed carrier-mixed samples.
- `early`, `prompt`, `late` in 1: code chips. 0 maps to +1, 1 maps to −1.
- `dump_enable` in 1: one-cycle pulse that ends the current integration period.
- `accum_read` in 1: one-cycle pulse from the CPU read strobe that acknowledges the latched data.
- `i_early`, `q_early`, `i_prompt`, `q_prompt`, `i_late`, `q_late` out ACC_W: latched sums.
- `new_data` out 1: set when a dump has latched sums that have not yet been read.
- `overrun` out 1: set when a dump occurs while `new_data` is still unread.

## Operation
- **Product:** each input is sign-extended to ACC_W and negated when the chip is 1. `-2^(IN_W-1)` negates exactly, because the result is ACC_W wide.
- **Sample without dump:** on `sample_enable` with no `dump_enable`, each accumulator adds its product.
- **Dump without sample:** on `dump_enable` with no `sample_enable`, each output latches its accumulator value and each accumulator loads 0.
- **Dump and sample in the same cycle:** outputs latch the accumulator value before this sample. Accumulators load this sample's product, so the sample is the first of the new period.
- **Flags on dump:** `new_data` is set. `overrun` is set if `new_data` was already 1 and `accum_read` is not asserted in the same cycle.
- **Read:** `accum_read` clears `new_data` and `overrun`.
- **Read and dump in the same cycle:** `new_data` ends at 1 and `overrun` ends at 0. The read acknowledges the old data; the dump produces new data.
- **`chan_clear`:** zeroes the accumulators, outputs and flags. It has priority over all other inputs in that cycle.
- **Reset:** `rstn` low asynchronously sets every accumulator, every output, `new_data` and `overrun` to 0.
- **Chip timing:** the early, prompt and late chips are sampled in the same cycle as `sample_enable`. No internal alignment delay is applied.

## Timing
- Accumulators update on the `clk` edge that samples `sample_enable`.
- Outputs and flags update on the edge that samples `dump_enable`, so they are valid the following cycle.
- Latency from the last contributing sample to the output is 1 clock.
- Back-to-back `dump_enable` pulses on consecutive cycles are legal. The second dump latches 0, or the single product if a sample arrived with the first dump.
- No state is held across `chan_clear`. Deasserting `rstn` mid-integration discards the partial sums.

## Configuration
- **`EPL_ACC_SAT_EN` defined:** each accumulator add saturates.
  - Positive overflow clamps to `2^(ACC_W-1)-1`.
  - Negative overflow clamps to `-2^(ACC_W-1)`.
  - Once clamped, the accumulator holds the rail until further products move it away.
- **`EPL_ACC_SAT_EN` undefined:** adds wrap modulo `2^ACC_W` in two's complement. No saturation logic is present.

## Test plan
- **Basic integration:** defaults. Send 10 samples with `i_bb=+3`, `q_bb=-2` and early/prompt/late = 0/0/1, then a lone dump. Required next cycle: `i_early=i_prompt=30`, `q_early=q_prompt=-20`, `i_late=-30`, `q_late=20`, `new_data=1`.
- **Dump coincident with sample:** 4 samples with `i_bb=+1`, prompt=0, then a 5th sample with `i_bb=+1` in the same cycle as `dump_enable`. Required: `i_prompt=4`. Then send a lone dump; required: `i_prompt=1`.
- **Negation of the most negative input:** `i_bb=-4` with prompt=1, 1 sample, then dump. Required: `i_prompt=+4`.
- **Flag handshake:**
  - Two dumps without a read: required `overrun=1`.
  - `accum_read` alone: required both flags 0.
  - `accum_read` in the same cycle as a dump: required `new_data=1`, `overrun=0`.
- **Saturation vs wrap:** `ACC_W=8`, 50 samples of `i_bb=+3` with prompt=0, then dump.
  - With `EPL_ACC_SAT_EN`: required `i_prompt=127`.
  - Without: required `i_prompt=-106` (150 wraps modulo 256).
- **Clear and reset:**
  - `chan_clear` asserted together with `sample_enable` and `dump_enable`: required all outputs and flags 0.
  - `rstn` pulled low mid-integration: outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/epl_accumulator.sv
// -----------------------------------------------------------------------------
// epl_accumulator
//   Tracking-channel early/prompt/late correlator. Each carrier-wiped I/Q
//   sample is multiplied by the early, prompt and late code chips (0 -> +1,
//   1 -> -1). Six integrate-and-dump accumulators sum the products. On
//   dump_enable the sums are latched to the outputs, and new_data/overrun
//   flags are raised for the CPU read path.
//
//   Optional feature macro: EPL_ACC_SAT_EN
//     defined   : accumulator adds saturate at the signed ACC_W rails
//     undefined : accumulator adds wrap modulo 2^ACC_W
//
// Ports
//   clk, rstn             : clock, async active-low reset
//   chan_clear            : synchronous clear of all state (highest priority)
//   sample_enable         : i_bb/q_bb/chips valid this cycle
//   i_bb, q_bb [IN_W]     : signed baseband samples
//   early, prompt, late   : code chips
//   dump_enable           : end of integration period
//   accum_read            : CPU acknowledge of latched sums
//   i_/q_ early/prompt/late [ACC_W] : latched sums
//   new_data, overrun     : handshake flags
// -----------------------------------------------------------------------------
module epl_accumulator #(
  parameter int IN_W  = 3,
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             chan_clear,
  input  logic             sample_enable,
  input  logic [IN_W-1:0]  i_bb,
  input  logic [IN_W-1:0]  q_bb,
  input  logic             early,
  input  logic             prompt,
  input  logic             late,
  input  logic             dump_enable,
  input  logic             accum_read,
  output logic [ACC_W-1:0] i_early,
  output logic [ACC_W-1:0] q_early,
  output logic [ACC_W-1:0] i_prompt,
  output logic [ACC_W-1:0] q_prompt,
  output logic [ACC_W-1:0] i_late,
  output logic [ACC_W-1:0] q_late,
  output logic             new_data,
  output logic             overrun
);

  localparam int unsigned N_CH  = 6;
  localparam int unsigned EXT_W = ACC_W - IN_W;

  // Channel order: 0 iE, 1 qE, 2 iP, 3 qP, 4 iL, 5 qL
  logic [ACC_W-1:0] acc_q [N_CH];
  logic [ACC_W-1:0] acc_d [N_CH];
  logic [ACC_W-1:0] out_q [N_CH];
  logic [ACC_W-1:0] out_d [N_CH];
  logic             new_data_q, new_data_d;
  logic             overrun_q,  overrun_d;

  logic [ACC_W-1:0] i_ext, q_ext;
  logic [ACC_W-1:0] prod [N_CH];

  // Sign-extend before negation so the most negative input negates exactly
  assign i_ext = {{EXT_W{i_bb[IN_W-1]}}, i_bb};
  assign q_ext = {{EXT_W{q_bb[IN_W-1]}}, q_bb};

  // Chip multiply: a 1 chip negates the sample
  always_comb begin
    prod[0] = early  ? (ACC_W'(0) - i_ext) : i_ext;
    prod[1] = early  ? (ACC_W'(0) - q_ext) : q_ext;
    prod[2] = prompt ? (ACC_W'(0) - i_ext) : i_ext;
    prod[3] = prompt ? (ACC_W'(0) - q_ext) : q_ext;
    prod[4] = late   ? (ACC_W'(0) - i_ext) : i_ext;
    prod[5] = late   ? (ACC_W'(0) - q_ext) : q_ext;
  end

  // Accumulator add: clamped to the signed rails or plain modular wrap
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
`ifdef EPL_ACC_SAT_EN
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1]) begin
      acc_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_add = s[ACC_W-1:0];
    end
`else
    acc_add = a + b;
`endif
  endfunction

  // Next-state: integrate, dump and flag handshake
  always_comb begin
    acc_d      = acc_q;
    out_d      = out_q;
    new_data_d = new_data_q;
    overrun_d  = overrun_q;
    if (chan_clear) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        acc_d[k] = '0;
        out_d[k] = '0;
      end
      new_data_d = 1'b0;
      overrun_d  = 1'b0;
    end else begin
      if (dump_enable) begin
        // A coincident sample opens the new period instead of closing the old
        for (int unsigned k = 0; k < N_CH; k++) begin
          out_d[k] = acc_q[k];
          acc_d[k] = sample_enable ? prod[k] : '0;
        end
      end else if (sample_enable) begin
        for (int unsigned k = 0; k < N_CH; k++) begin
          acc_d[k] = acc_add(acc_q[k], prod[k]);
        end
      end
      if (accum_read) begin
        new_data_d = 1'b0;
        overrun_d  = 1'b0;
      end
      // A read in the same cycle acknowledges the old data, so no overrun
      if (dump_enable) begin
        new_data_d = 1'b1;
        if (new_data_q && !accum_read) begin
          overrun_d = 1'b1;
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        acc_q[k] <= '0;
        out_q[k] <= '0;
      end
      new_data_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      out_q      <= out_d;
      new_data_q <= new_data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign i_early  = out_q[0];
  assign q_early  = out_q[1];
  assign i_prompt = out_q[2];
  assign q_prompt = out_q[3];
  assign i_late   = out_q[4];
  assign q_late   = out_q[5];
  assign new_data = new_data_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_epl_accumulator.sv
// -----------------------------------------------------------------------------
// tb_epl_accumulator
//   Drives a default-width (ACC_W=16) and a narrow (ACC_W=8) instance from
//   the same stimulus. An integer model of the correlator tracks both widths
//   and every output is compared on each falling clock edge; directed
//   sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_epl_accumulator;

  localparam int IN_W = 3;
  localparam int WA   = 16;
  localparam int WB   = 8;

  logic clk;
  logic rstn;
  logic chan_clear, sample_enable, dump_enable, accum_read;
  logic early, prompt, late;
  logic [IN_W-1:0] i_bb, q_bb;

  logic [WA-1:0] a_ie, a_qe, a_ip, a_qp, a_il, a_ql;
  logic [WB-1:0] b_ie, b_qe, b_ip, b_qp, b_il, b_ql;
  logic a_nd, a_ov, b_nd, b_ov;

  int checks = 0;
  int errors = 0;

  epl_accumulator #(.IN_W(IN_W), .ACC_W(WA)) dut_a (
    .clk(clk), .rstn(rstn), .chan_clear(chan_clear), .sample_enable(sample_enable),
    .i_bb(i_bb), .q_bb(q_bb), .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .accum_read(accum_read),
    .i_early(a_ie), .q_early(a_qe), .i_prompt(a_ip), .q_prompt(a_qp),
    .i_late(a_il), .q_late(a_ql), .new_data(a_nd), .overrun(a_ov));

  epl_accumulator #(.IN_W(IN_W), .ACC_W(WB)) dut_b (
    .clk(clk), .rstn(rstn), .chan_clear(chan_clear), .sample_enable(sample_enable),
    .i_bb(i_bb), .q_bb(q_bb), .early(early), .prompt(prompt), .late(late),
    .dump_enable(dump_enable), .accum_read(accum_read),
    .i_early(b_ie), .q_early(b_qe), .i_prompt(b_ip), .q_prompt(b_qp),
    .i_late(b_il), .q_late(b_ql), .new_data(b_nd), .overrun(b_ov));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int  m_acc [2][6];
  int  m_out [2][6];
  bit  m_nd, m_ov;

  function automatic int fold(input int s, input int w);
    int hi, lo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -(1 <<< (w - 1));
`ifdef EPL_ACC_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    s = s & ((1 <<< w) - 1);
    if (s > hi) s = s - (1 <<< w);
    return s;
`endif
  endfunction

  always @(posedge clk or negedge rstn) begin
    int x, y, w;
    int p [6];
    bit nd_old;
    if (!rstn) begin
      for (int d = 0; d < 2; d++)
        for (int k = 0; k < 6; k++) begin m_acc[d][k] = 0; m_out[d][k] = 0; end
      m_nd = 0; m_ov = 0;
    end else begin
      x = $signed(i_bb);
      y = $signed(q_bb);
      p[0] = early  ? -x : x;  p[1] = early  ? -y : y;
      p[2] = prompt ? -x : x;  p[3] = prompt ? -y : y;
      p[4] = late   ? -x : x;  p[5] = late   ? -y : y;
      if (chan_clear) begin
        for (int d = 0; d < 2; d++)
          for (int k = 0; k < 6; k++) begin m_acc[d][k] = 0; m_out[d][k] = 0; end
        m_nd = 0; m_ov = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          w = (d == 0) ? WA : WB;
          for (int k = 0; k < 6; k++) begin
            if (dump_enable) begin
              m_out[d][k] = m_acc[d][k];
              m_acc[d][k] = sample_enable ? p[k] : 0;
            end else if (sample_enable) begin
              m_acc[d][k] = fold(m_acc[d][k] + p[k], w);
            end
          end
        end
        nd_old = m_nd;
        if (accum_read) begin m_nd = 0; m_ov = 0; end
        if (dump_enable) begin
          if (nd_old && !accum_read) m_ov = 1;
          m_nd = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int ga [6];
    int gb [6];
    if (rstn === 1'b1) begin
      ga[0] = $signed(a_ie); ga[1] = $signed(a_qe); ga[2] = $signed(a_ip);
      ga[3] = $signed(a_qp); ga[4] = $signed(a_il); ga[5] = $signed(a_ql);
      gb[0] = $signed(b_ie); gb[1] = $signed(b_qe); gb[2] = $signed(b_ip);
      gb[3] = $signed(b_qp); gb[4] = $signed(b_il); gb[5] = $signed(b_ql);
      for (int k = 0; k < 6; k++) begin
        chk($sformatf("w16_out%0d", k), ga[k], m_out[0][k]);
        chk($sformatf("w8_out%0d", k), gb[k], m_out[1][k]);
      end
      chk("w16_new_data", int'(a_nd), int'(m_nd));
      chk("w16_overrun",  int'(a_ov), int'(m_ov));
      chk("w8_new_data",  int'(b_nd), int'(m_nd));
      chk("w8_overrun",   int'(b_ov), int'(m_ov));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit s, input bit d, input bit r, input bit c,
                     input int iv, input int qv, input bit e, input bit p, input bit l);
    sample_enable = s; dump_enable = d; accum_read = r; chan_clear = c;
    i_bb = IN_W'(iv); q_bb = IN_W'(qv);
    early = e; prompt = p; late = l;
    @(posedge clk);
    #1;
    sample_enable = 0; dump_enable = 0; accum_read = 0; chan_clear = 0;
  endtask

  task automatic clr();
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    chan_clear = 0; sample_enable = 0; dump_enable = 0; accum_read = 0;
    early = 0; prompt = 0; late = 0; i_bb = '0; q_bb = '0;
    #2;
    chk("reset_i_prompt", int'($signed(a_ip)), 0);
    chk("reset_new_data", int'(a_nd), 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Basic integration
    clr();
    repeat (10) cyc(1, 0, 0, 0, 3, -2, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("basic_i_early",  $signed(a_ie), 30);
    chk("basic_i_prompt", $signed(a_ip), 30);
    chk("basic_q_early",  $signed(a_qe), -20);
    chk("basic_q_prompt", $signed(a_qp), -20);
    chk("basic_i_late",   $signed(a_il), -30);
    chk("basic_q_late",   $signed(a_ql), 20);
    chk("basic_new_data", int'(a_nd), 1);

    // Dump coincident with sample, then back-to-back style lone dump
    clr();
    repeat (4) cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 0, 0, 0, 0);
    chk("coinc_i_prompt", $signed(a_ip), 4);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("coinc_next_i_prompt", $signed(a_ip), 1);
    chk("two_dumps_overrun", int'(a_ov), 1);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("read_new_data", int'(a_nd), 0);
    chk("read_overrun",  int'(a_ov), 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    chk("rd_dump_new_data", int'(a_nd), 1);
    chk("rd_dump_overrun",  int'(a_ov), 0);

    // Most negative input negated
    clr();
    cyc(1, 0, 0, 0, -4, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("neg_min_w16", $signed(a_ip), 4);
    chk("neg_min_w8",  $signed(b_ip), 4);

    // Saturation versus wrap on the narrow instance
    clr();
    repeat (50) cyc(1, 0, 0, 0, 3, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_w16_i_prompt", $signed(a_ip), 150);
`ifdef EPL_ACC_SAT_EN
    chk("sat_w8_i_prompt", $signed(b_ip), 127);
`else
    chk("wrap_w8_i_prompt", $signed(b_ip), -106);
`endif

    // Clear has priority over sample and dump
    cyc(1, 0, 0, 0, 2, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 1, 3, 3, 0, 0, 0);
    chk("clr_i_prompt", $signed(a_ip), 0);
    chk("clr_q_late",   $signed(a_ql), 0);
    chk("clr_new_data", int'(a_nd), 0);
    chk("clr_overrun",  int'(a_ov), 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_acc_zero", $signed(a_ie), 0);

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(99) < 60), ($urandom_range(99) < 6),
          ($urandom_range(99) < 10), ($urandom_range(999) < 8),
          int'($urandom_range(7)) - 4, int'($urandom_range(7)) - 4,
          1'($urandom), 1'($urandom), 1'($urandom));
    end
    // Long saturating/wrapping runs on the narrow instance
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(150, 20)) cyc(1, 0, 0, 0, (n % 2) ? -4 : 3, 2, n[0], 0, 1);
      repeat ($urandom_range(40)) cyc(1, 0, 0, 0, int'($urandom_range(7)) - 4, 1, 0, 1, 0);
      cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
    end

    // Asynchronous reset mid-integration
    repeat (3) cyc(1, 0, 0, 0, 3, 3, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 3, 3, 0, 0, 0);
    chk("pre_rst_i_prompt", $signed(a_ip), 9);
    #1 rstn = 1'b0;
    #1;
    chk("async_rst_i_prompt", $signed(a_ip), 0);
    chk("async_rst_q_early",  $signed(a_qe), 0);
    chk("async_rst_new_data", int'(a_nd), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_dump", $signed(a_ip), 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
